// File: rtl/hash_enc_pkg.sv
// Shared definitions for the hash-encoding pipeline: feature/index widths,
// corner count, default table depth and the feature-fetch state encoding.
package hash_enc_pkg;

  localparam int HALF_SIZE   = 16;
  localparam int DATA_SIZE   = 32;
  localparam int NUM_CORNERS = 8;
  localparam int TABLE_SIZE  = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/hash_feat_fetch.sv
// Feature fetch stage: takes one group of eight per-corner hash indices,
// reads the matching words from a synchronous-read hash-table SRAM one per
// cycle, and hands the complete group of eight feature words downstream.
module hash_feat_fetch #(
  parameter  int DATA_SIZE   = hash_enc_pkg::DATA_SIZE,
  parameter  int FEAT_SIZE   = 2 * hash_enc_pkg::HALF_SIZE,
  parameter  int TABLE_SIZE  = hash_enc_pkg::TABLE_SIZE,
  localparam int ADDR_W      = $clog2(TABLE_SIZE),
  localparam int NUM_CORNERS = hash_enc_pkg::NUM_CORNERS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] hash_idx [NUM_CORNERS],
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [FEAT_SIZE-1:0] mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FEAT_SIZE-1:0] feat [NUM_CORNERS],
  output logic                 busy
);

  import hash_enc_pkg::*;

  localparam int CNT_W = $clog2(NUM_CORNERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CORNERS - 1);

  // Masking by bit-slice only equals "modulo TABLE_SIZE" for powers of two.
  if ((TABLE_SIZE & (TABLE_SIZE - 1)) != 0) begin : g_bad_table_size
    $error("hash_feat_fetch: TABLE_SIZE must be a power of two");
  end

  fetch_state_t      state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [CNT_W-1:0]  cap_cnt_q;
  logic              cap_vld_q;
  logic [ADDR_W-1:0] idx_q [NUM_CORNERS];
  logic              unused_idx_hi;

  // Index bits above the table address are intentionally discarded.
  always_comb begin
    unused_idx_hi = 1'b0;
    for (int i = 0; i < NUM_CORNERS; i++) begin
      unused_idx_hi = unused_idx_hi ^ (^hash_idx[i][DATA_SIZE-1:ADDR_W]);
    end
  end

  // Next-state and output decode; every output is a function of state only,
  // so out_valid and in_ready never see a combinational path from the inputs.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = idx_q[issue_cnt_q];
        if (issue_cnt_q == LAST_CNT) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus issue counter and the read-return tracker.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      cap_vld_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Synchronous-read SRAM: data for a request appears one cycle later.
      cap_vld_q <= mem_req;
      if (state_q == ISSUE) begin
        issue_cnt_q <= (issue_cnt_q == LAST_CNT) ? '0 : issue_cnt_q + 1'b1;
      end
    end
  end

  // Latch the masked corner indices when a group is accepted.
  // NOTE: these small register banks are reset because their reset value is observable; real SRAM arrays are not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CORNERS; i++) idx_q[i] <= '0;
    end else if (state_q == IDLE && in_valid) begin
      for (int i = 0; i < NUM_CORNERS; i++) idx_q[i] <= hash_idx[i][ADDR_W-1:0];
    end
  end

  // Capture returning SRAM words in corner order; feat holds until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cnt_q <= '0;
      for (int i = 0; i < NUM_CORNERS; i++) feat[i] <= '0;
    end else if (cap_vld_q) begin
      feat[cap_cnt_q] <= mem_rdata;
      cap_cnt_q       <= (cap_cnt_q == LAST_CNT) ? '0 : cap_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hash_feat_fetch.sv
// Directed bench for hash_feat_fetch: table of index groups with expected
// SRAM addresses, plus sequences for backpressure, back-to-back and reset.
module tb_hash_feat_fetch;

  localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] idx  [8];
    logic [11:0] addr [8];
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] hash_idx [8];
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] feat [8];
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_q [$];
  vec_t vecs [3];

  hash_feat_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hash_idx  (hash_idx),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .feat      (feat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read SRAM model: mem[a] = a ^ 32'hA5A50000; junk when idle.
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= {20'h0, mem_addr} ^ MEM_XOR;
    else         mem_rdata <= 32'hDEAD_BEEF;
  end

  // Cycle counter and input-accept log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic check_feats(input string name, input vec_t v);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_feat%0d", name, i), feat[i], {20'h0, v.addr[i]} ^ MEM_XOR);
  endtask

  task automatic wait_out_valid(input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    timeout(name);
  endtask

  // Present a group and check the exact issue/capture/valid timeline.
  // Returns in cycle T+10 with out_valid expected high; out_ready is left alone.
  task automatic run_vec(input string name, input vec_t v);
    @(negedge clk);
    in_valid = 1'b1;
    hash_idx = v.idx;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s_req%0d", name, k), 32'(mem_req), 32'd1);
      check($sformatf("%s_addr%0d", name, k), 32'(mem_addr), 32'(v.addr[k]));
      check($sformatf("%s_ovld_issue%0d", name, k), 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check({name, "_drain_req"}, 32'(mem_req), 32'd0);
    check({name, "_drain_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_drain_ovld"}, 32'(out_valid), 32'd0);
    check({name, "_drain_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    check({name, "_done_in_ready"}, 32'(in_ready), 32'd0);
    check_feats(name, v);
  endtask

  initial begin
    vecs[0].idx  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    vecs[0].addr = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007};
    vecs[1].idx  = '{32'h10, 32'h20, 32'h30, 32'h0001_2FFF, 32'hFFFF_F001, 32'h5, 32'h5, 32'h800};
    vecs[1].addr = '{12'h010, 12'h020, 12'h030, 12'hFFF, 12'h001, 12'h005, 12'h005, 12'h800};
    vecs[2].idx  = '{32'h8000_0ABC, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1000,
                     32'h0FFF, 32'h7FF, 32'h0C00, 32'h0001_0001};
    vecs[2].addr = '{12'hABC, 12'h678, 12'hFFF, 12'h000, 12'hFFF, 12'h7FF, 12'hC00, 12'h001};

    // Reset then idle.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hash_idx  = vecs[0].idx;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_feat%0d", i), feat[i], 32'd0);

    // Table-driven fetches with out_ready high; feat must persist afterwards.
    for (int t = 0; t < 3; t++) begin
      run_vec($sformatf("vec%0d", t), vecs[t]);
      @(negedge clk);
      check($sformatf("vec%0d_post_ovld", t), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d_post_in_ready", t), 32'(in_ready), 32'd1);
      check($sformatf("vec%0d_post_feat3", t), feat[3], {20'h0, vecs[t].addr[3]} ^ MEM_XOR);
    end

    // Backpressure: hold out_ready low 20 cycles with a second group waiting.
    out_ready = 1'b0;
    run_vec("bp", vecs[1]);
    acc_q.delete();
    in_valid = 1'b1;
    hash_idx = vecs[2].idx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_ovld%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_in_ready%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("bp_hold_feat3_%0d", i), feat[3], 32'hA5A5_0FFF);
      check($sformatf("bp_hold_req%0d", i), 32'(mem_req), 32'd0);
    end
    check("bp_no_early_accept", 32'(acc_q.size()), 32'd0);
    begin
      int h;
      bit got;
      out_ready = 1'b1;
      h   = cyc;
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
        @(negedge clk);
        if (acc_q.size() > 0) got = 1'b1;
      end
      in_valid = 1'b0;
      if (!got) timeout("bp_accept");
      else check("bp_accept_cycle", 32'(acc_q[0]), 32'(h + 1));
    end
    wait_out_valid("bp_second_valid");
    check_feats("bp_second", vecs[2]);

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    acc_q.delete();
    in_valid = 1'b1;
    hash_idx = vecs[0].idx;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
        @(negedge clk);
        if (acc_q.size() > 0) got = 1'b1;
      end
      if (!got) timeout("b2b_first_accept");
    end
    hash_idx = vecs[2].idx;
    wait_out_valid("b2b_first_valid");
    check_feats("b2b_first", vecs[0]);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (acc_q.size() > 1) got = 1'b1;
      end
      in_valid = 1'b0;
      if (!got) timeout("b2b_second_accept");
      else check("b2b_accept_gap", 32'(acc_q[1] - acc_q[0]), 32'd11);
    end
    wait_out_valid("b2b_second_valid");
    check_feats("b2b_second", vecs[2]);

    // Mid-operation reset at T+4, then a clean fetch.
    @(negedge clk);
    in_valid = 1'b1;
    hash_idx = vecs[1].idx;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_mem_req", 32'(mem_req), 32'd0);
    check("mrst_mem_addr", 32'(mem_addr), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_feat0", feat[0], 32'd0);
    check("mrst_feat7", feat[7], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_idle_feat7", feat[7], 32'd0);
    run_vec("mrst_after", vecs[0]);
    @(negedge clk);
    check("mrst_after_ovld", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
